apb_pcie_mst: RTL and testbench

- APB initiator (master) driven by the PCIe DMA engine: converts one inbound 32/64-bit request into one or two APB4 transfers on the system APB bus.
- Returns a single merged response to the DMA side.
- Complements the APB-slave PCIe control block: the host reaches APB peripherals through this block instead of only observing DMA state.
- One request in flight at a time; no buffering beyond one request.

---
 rtl/apb_pcie_mst.sv | 165 ++++++++++++++++
 tb/tb_apb_pcie_mst.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pcie_mst.sv
// APB4 initiator for the PCIe DMA engine: one 32/64-bit request becomes one or
// two APB transfers, and a single merged response goes back to the DMA side.
module apb_pcie_mst #(
    parameter int unsigned timeout = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_write,
    input  logic        i_req_size64,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    output logic [3:0]  o_pstrb,
    output logic [2:0]  o_pprot,
    input  logic        i_pready,
    input  logic        i_pslverr,
    input  logic [31:0] i_prdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (timeout < 2) ? 1 : $clog2(timeout);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((timeout == 0) ? 0 : timeout - 1);

    state_t            state_reg;
    logic              beat_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:3]       addr_reg;
    logic              write_reg;
    logic              size64_reg;
    logic [31:0]       wdata_hi_reg;
    logic [3:0]        wstrb_hi_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [31:0]       paddr_reg;
    logic [31:0]       pwdata_reg;
    logic [3:0]        pstrb_reg;
    logic              resp_valid_reg;
    logic [63:0]       resp_rdata_reg;
    logic              resp_err_reg;

    // Byte offset within a word is carried by the strobes, never by paddr.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_req_addr[1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            beat_reg       <= 1'b0;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            write_reg      <= 1'b0;
            size64_reg     <= 1'b0;
            wdata_hi_reg   <= '0;
            wstrb_hi_reg   <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            pstrb_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_reg       <= i_req_addr[31:3];
                        write_reg      <= i_req_write;
                        size64_reg     <= i_req_size64;
                        wdata_hi_reg   <= i_req_wdata[63:32];
                        wstrb_hi_reg   <= i_req_wstrb[7:4];
                        resp_rdata_reg <= '0;
                        beat_reg       <= 1'b0;
                        cnt_reg        <= '0;
                        // A 64-bit request must start on an 8-byte boundary.
                        if (i_req_size64 && i_req_addr[2]) begin
                            resp_err_reg   <= 1'b1;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            resp_err_reg <= 1'b0;
                            psel_reg     <= 1'b1;
                            penable_reg  <= 1'b0;
                            pwrite_reg   <= i_req_write;
                            paddr_reg    <= {i_req_addr[31:2], 2'b00};
                            pwdata_reg   <= i_req_wdata[31:0];
                            pstrb_reg    <= i_req_write ? i_req_wstrb[3:0] : 4'b0000;
                            state_reg    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (i_pready) begin
                        psel_reg    <= 1'b0;
                        penable_reg <= 1'b0;
                        cnt_reg     <= '0;
                        if (!write_reg) begin
                            if (beat_reg) resp_rdata_reg[63:32] <= i_prdata;
                            else          resp_rdata_reg[31:0]  <= i_prdata;
                        end
                        resp_err_reg <= resp_err_reg | i_pslverr;
                        // Second beat only after a clean first beat.
                        if (size64_reg && !beat_reg && !i_pslverr) begin
                            beat_reg   <= 1'b1;
                            psel_reg   <= 1'b1;
                            paddr_reg  <= {addr_reg, 3'b100};
                            pwdata_reg <= wdata_hi_reg;
                            pstrb_reg  <= write_reg ? wstrb_hi_reg : 4'b0000;
                            state_reg  <= SETUP;
                        end else begin
                            resp_valid_reg <= 1'b1;
                            state_reg      <= RESP;
                        end
                    end else if (timeout != 0 && cnt_reg == CNT_LAST) begin
                        psel_reg       <= 1'b0;
                        penable_reg    <= 1'b0;
                        cnt_reg        <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = (state_reg == IDLE);
    assign o_resp_valid = resp_valid_reg;
    assign o_resp_rdata = resp_rdata_reg;
    assign o_resp_err   = resp_err_reg;
    assign o_psel       = psel_reg;
    assign o_penable    = penable_reg;
    assign o_pwrite     = pwrite_reg;
    assign o_paddr      = paddr_reg;
    assign o_pwdata     = pwdata_reg;
    assign o_pstrb      = pstrb_reg;
    assign o_pprot      = 3'b000;

endmodule

// File: tb/tb_apb_pcie_mst.sv
// Bench for apb_pcie_mst: randomized DMA requests against an APB completer model,
// checked every cycle against a transaction-level reference model.
module tb_apb_pcie_mst;
    localparam int unsigned TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_write;
    logic        i_req_size64;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [63:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic [2:0]  o_pprot;
    logic        i_pready;
    logic        i_pslverr;
    logic [31:0] i_prdata;

    apb_pcie_mst #(.timeout(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_size64(i_req_size64), .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
        .o_pprot(o_pprot),
        .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    xfer_t exp_xfer[$];
    resp_t exp_resp[$];

    int checks = 0;
    int errors = 0;

    // Completer plan for the current request, indexed by beat.
    int          plan_w[2];
    logic        plan_e[2];
    logic [31:0] plan_rd[2];
    logic        cur_size64 = 1'b0;

    int          n_setup = 0;
    int          n_access = 0;
    logic [31:0] last_paddr = '0;
    logic [3:0]  last_pstrb = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: which APB transfers a request produces and what comes back.
    task automatic model(input logic [31:0] addr, input logic write, input logic size64,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
        resp_t r;
        xfer_t x;
        int    nb;
        r.rdata = '0;
        r.err   = 1'b0;
        r.lat   = 1;
        if (size64 && addr[2]) begin
            r.err = 1'b1;
            exp_resp.push_back(r);
            return;
        end
        nb = size64 ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            x.addr  = size64 ? ((addr & ~32'h7) + 32'(4 * b)) : (addr & ~32'h3);
            x.write = write;
            x.wdata = (b == 0) ? wdata[31:0] : wdata[63:32];
            x.strb  = !write ? 4'h0 : ((b == 0) ? wstrb[3:0] : wstrb[7:4]);
            exp_xfer.push_back(x);
            if (TO != 0 && plan_w[b] >= int'(TO)) begin
                r.err = 1'b1;
                r.lat += 1 + int'(TO);
                break;
            end
            r.lat += 2 + plan_w[b];
            if (!write) r.rdata[b*32 +: 32] = plan_rd[b];
            if (plan_e[b]) begin
                r.err = 1'b1;
                break;
            end
        end
        exp_resp.push_back(r);
    endtask

    // APB completer: answers after plan_w wait states, drives noise otherwise.
    initial begin : slave
        int sb;
        int acnt;
        sb = 0;
        acnt = 0;
        i_pready = 1'b0;
        i_pslverr = 1'b0;
        i_prdata = '0;
        forever begin
            @(negedge i_clk);
            if (o_psel && !o_penable) begin
                sb = (cur_size64 && o_paddr[2]) ? 1 : 0;
                acnt = 0;
                i_pready  = 1'($urandom_range(0, 1));
                i_pslverr = 1'($urandom_range(0, 1));
                i_prdata  = $urandom;
            end else if (o_psel && o_penable) begin
                if (acnt == plan_w[sb]) begin
                    i_pready  = 1'b1;
                    i_pslverr = plan_e[sb];
                    i_prdata  = plan_rd[sb];
                end else begin
                    i_pready  = 1'b0;
                    i_pslverr = 1'($urandom_range(0, 1));
                    i_prdata  = $urandom;
                end
                acnt++;
            end else begin
                i_pready  = 1'($urandom_range(0, 1));
                i_pslverr = 1'($urandom_range(0, 1));
                i_prdata  = $urandom;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model queues.
    initial begin : compare
        int    ncyc;
        int    acc_cyc;
        bit    busy;
        bit    in_resp;
        bit    in_xfer;
        xfer_t cx;
        resp_t er;
        logic [63:0] r_rd;
        logic        r_err;
        ncyc = 0; acc_cyc = 0; busy = 0; in_resp = 0; in_xfer = 0;
        r_rd = '0; r_err = 1'b0;
        forever begin
            @(negedge i_clk);
            ncyc++;
            if (i_rst) begin
                busy = 0; in_resp = 0; in_xfer = 0;
                continue;
            end
            check("pprot", 64'(o_pprot), 64'd0);
            if (o_penable) check("penable_implies_psel", 64'(o_psel), 64'd1);
            if (o_psel) check("paddr_lsb", 64'(o_paddr[1:0]), 64'd0);
            if (busy) begin
                check("req_ready_busy", 64'(o_req_ready), 64'd0);
            end else begin
                check("req_ready_idle", 64'(o_req_ready), 64'd1);
                if (i_req_valid) begin
                    busy = 1;
                    acc_cyc = ncyc;
                end
            end
            if (o_psel && !o_penable) begin
                n_setup++;
                last_paddr = o_paddr;
                last_pstrb = o_pstrb;
                checks++;
                if (exp_xfer.size() == 0) begin
                    errors++;
                    in_xfer = 0;
                    $display("FAIL unexpected_setup: paddr 0x%0h, no transfer expected", o_paddr);
                end else begin
                    cx = exp_xfer.pop_front();
                    in_xfer = 1;
                    check("setup_paddr", 64'(o_paddr), 64'(cx.addr));
                    check("setup_pwrite", 64'(o_pwrite), 64'(cx.write));
                    check("setup_pstrb", 64'(o_pstrb), 64'(cx.strb));
                    if (cx.write) check("setup_pwdata", 64'(o_pwdata), 64'(cx.wdata));
                end
            end else if (o_psel && o_penable) begin
                n_access++;
                check("access_after_setup", 64'(in_xfer), 64'd1);
                if (in_xfer) begin
                    check("access_paddr", 64'(o_paddr), 64'(cx.addr));
                    check("access_pwrite", 64'(o_pwrite), 64'(cx.write));
                    check("access_pstrb", 64'(o_pstrb), 64'(cx.strb));
                    if (cx.write) check("access_pwdata", 64'(o_pwdata), 64'(cx.wdata));
                end
            end
            if (o_resp_valid) begin
                check("psel_low_in_resp", 64'(o_psel), 64'd0);
                if (!in_resp) begin
                    checks++;
                    if (exp_resp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: rdata 0x%0h err %0d", o_resp_rdata, o_resp_err);
                    end else begin
                        er = exp_resp.pop_front();
                        check("resp_rdata", o_resp_rdata, er.rdata);
                        check("resp_err", 64'(o_resp_err), 64'(er.err));
                        check("resp_latency", 64'(ncyc - acc_cyc), 64'(er.lat));
                    end
                    in_resp = 1;
                    r_rd = o_resp_rdata;
                    r_err = o_resp_err;
                end else begin
                    check("resp_rdata_stable", o_resp_rdata, r_rd);
                    check("resp_err_stable", 64'(o_resp_err), 64'(r_err));
                end
                if (i_resp_ready) begin
                    in_resp = 0;
                    busy = 0;
                end
            end else if (in_resp) begin
                check("resp_valid_held", 64'(o_resp_valid), 64'd1);
                in_resp = 0;
            end
        end
    end

    // Issue one request; returns the response seen at the handshake.
    task automatic run_req(input logic [31:0] addr, input logic write, input logic size64,
                           input logic [63:0] wdata, input logic [7:0] wstrb,
                           input int w0, input int w1, input logic e0, input logic e1,
                           input logic [31:0] rd0, input logic [31:0] rd1, input int hold,
                           output logic [63:0] rdata, output logic err, output int lat);
        bit acc;
        bit seen;
        bit done;
        int cyc;
        int held;
        plan_w[0] = w0; plan_w[1] = w1;
        plan_e[0] = e0; plan_e[1] = e1;
        plan_rd[0] = rd0; plan_rd[1] = rd1;
        cur_size64 = size64;
        model(addr, write, size64, wdata, wstrb);
        rdata = '0; err = 1'b0; lat = 0;
        i_req_addr = addr; i_req_write = write; i_req_size64 = size64;
        i_req_wdata = wdata; i_req_wstrb = wstrb;
        i_req_valid = 1'b1; i_resp_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge i_clk);
            acc = o_req_ready;
            @(posedge i_clk);
            #2;
        end
        i_req_valid = 1'b0;
        i_req_addr = $urandom; i_req_write = 1'($urandom_range(0, 1));
        i_req_size64 = 1'($urandom_range(0, 1));
        i_req_wdata = {$urandom, $urandom}; i_req_wstrb = 8'($urandom);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: o_req_ready never rose for addr 0x%0h", addr);
            return;
        end
        seen = 0; done = 0; cyc = 0; held = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (hold < 0) i_resp_ready = ($urandom_range(0, 2) != 0);
            else          i_resp_ready = seen && (held >= hold);
            @(negedge i_clk);
            cyc++;
            if (o_resp_valid && !seen) begin
                seen = 1;
                lat = cyc;
            end
            if (o_resp_valid && i_resp_ready) begin
                rdata = o_resp_rdata;
                err = o_resp_err;
                done = 1;
            end else if (seen) begin
                held++;
            end
            @(posedge i_clk);
            #2;
        end
        i_resp_ready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no response handshake for addr 0x%0h", addr);
        end
    endtask

    // Reset in the middle of ACCESS (at_resp=0) or while holding a response (at_resp=1).
    task automatic reset_mid(input bit at_resp);
        int n;
        plan_w[0] = 6; plan_w[1] = 0;
        plan_e[0] = 1'b0; plan_e[1] = 1'b0;
        plan_rd[0] = 32'hA5A5A5A5; plan_rd[1] = 32'h5A5A5A5A;
        cur_size64 = 1'b1;
        model(32'h7000, 1'b0, 1'b1, 64'd0, 8'hFF);
        i_req_addr = 32'h7000; i_req_write = 1'b0; i_req_size64 = 1'b1;
        i_req_valid = 1'b1; i_resp_ready = 1'b0;
        @(posedge i_clk);
        #2;
        i_req_valid = 1'b0;
        n = 0;
        while (!(at_resp ? o_resp_valid : (o_psel && o_penable)) && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check("reset_reach_phase", 64'(n < 60), 64'd1);
        #1 i_rst = 1'b1;
        #1;
        check("rst_psel_drop", 64'(o_psel), 64'd0);
        check("rst_penable_drop", 64'(o_penable), 64'd0);
        check("rst_resp_valid_drop", 64'(o_resp_valid), 64'd0);
        check("rst_resp_err", 64'(o_resp_err), 64'd0);
        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        exp_xfer.delete();
        exp_resp.delete();
        @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        @(posedge i_clk);
        #2;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          s0;
        int          a0;
        logic [31:0] ra;
        logic        rw;
        logic        rs;
        int          w0;
        int          w1;

        i_rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_write = 1'b0;
        i_req_size64 = 1'b0; i_req_wdata = '0; i_req_wstrb = '0; i_resp_ready = 1'b0;
        plan_w[0] = 0; plan_w[1] = 0; plan_e[0] = 1'b0; plan_e[1] = 1'b0;
        plan_rd[0] = '0; plan_rd[1] = '0;
        repeat (3) @(posedge i_clk);
        #2;
        check("reset_psel", 64'(o_psel), 64'd0);
        check("reset_penable", 64'(o_penable), 64'd0);
        check("reset_pwrite", 64'(o_pwrite), 64'd0);
        check("reset_paddr", 64'(o_paddr), 64'd0);
        check("reset_pwdata", 64'(o_pwdata), 64'd0);
        check("reset_pstrb", 64'(o_pstrb), 64'd0);
        check("reset_resp_valid", 64'(o_resp_valid), 64'd0);
        check("reset_resp_rdata", o_resp_rdata, 64'd0);
        check("reset_resp_err", 64'(o_resp_err), 64'd0);
        check("reset_req_ready", 64'(o_req_ready), 64'd1);
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;

        // 32-bit write, zero-wait completer
        run_req(32'h1004, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 1'b0, 1'b0,
                32'h0, 32'h0, -1, rd, er, lat);
        check("wr32_latency", 64'(lat), 64'd3);
        check("wr32_err", 64'(er), 64'd0);
        check("wr32_rdata", rd, 64'd0);
        check("wr32_paddr", 64'(last_paddr), 64'h1004);
        check("wr32_pstrb", 64'(last_pstrb), 64'hF);

        // 64-bit read, two wait states per beat
        run_req(32'h2000, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2, 2, 1'b0, 1'b0,
                32'h11111111, 32'h22222222, -1, rd, er, lat);
        check("rd64_rdata", rd, 64'h2222_2222_1111_1111);
        check("rd64_err", 64'(er), 64'd0);
        check("rd64_latency", 64'(lat), 64'd9);
        check("rd64_paddr_beat1", 64'(last_paddr), 64'h2004);
        check("rd64_pstrb", 64'(last_pstrb), 64'd0);

        // slave error on beat 0 of a 64-bit write aborts beat 1
        s0 = n_setup;
        run_req(32'h4000, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 0, 0, 1'b1, 1'b0,
                32'h0, 32'h0, -1, rd, er, lat);
        check("slverr_err", 64'(er), 64'd1);
        check("slverr_setups", 64'(n_setup - s0), 64'd1);
        check("slverr_latency", 64'(lat), 64'd3);

        // timeout, then a normal request
        a0 = n_access;
        run_req(32'h5008, 1'b0, 1'b0, 64'd0, 8'h0F, 40, 0, 1'b0, 1'b0,
                32'h0, 32'h0, -1, rd, er, lat);
        check("timeout_err", 64'(er), 64'd1);
        check("timeout_access_cycles", 64'(n_access - a0), 64'd16);
        check("timeout_latency", 64'(lat), 64'd18);
        run_req(32'h500C, 1'b0, 1'b0, 64'd0, 8'h0F, 0, 0, 1'b0, 1'b0,
                32'hCAFEF00D, 32'h0, -1, rd, er, lat);
        check("post_timeout_rdata", rd, 64'h0000_0000_CAFE_F00D);
        check("post_timeout_err", 64'(er), 64'd0);

        // misaligned 64-bit request: no APB traffic
        s0 = n_setup;
        run_req(32'h3004, 1'b0, 1'b1, 64'd0, 8'hFF, 0, 0, 1'b0, 1'b0,
                32'h1, 32'h2, -1, rd, er, lat);
        check("misalign_latency", 64'(lat), 64'd1);
        check("misalign_err", 64'(er), 64'd1);
        check("misalign_rdata", rd, 64'd0);
        check("misalign_setups", 64'(n_setup - s0), 64'd0);

        // response back-pressure for 10 cycles
        run_req(32'h6000, 1'b0, 1'b1, 64'd0, 8'hFF, 1, 0, 1'b0, 1'b0,
                32'h0BAD_F00D, 32'h7777_0000, 10, rd, er, lat);
        check("bp_rdata", rd, 64'h7777_0000_0BAD_F00D);
        check("bp_err", 64'(er), 64'd0);

        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int k = 0; k < 300; k++) begin
            ra = $urandom;
            rw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (rs && $urandom_range(0, 7) != 0) ra[2] = 1'b0;
            w0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
            w1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
            run_req(ra, rw, rs, {$urandom, $urandom}, 8'($urandom), w0, w1,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    $urandom, $urandom, -1, rd, er, lat);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #2;
        end

        repeat (3) @(posedge i_clk);
        #2;
        check("xfer_queue_drained", 64'(exp_xfer.size()), 64'd0);
        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
